stopwatch_btn_cmd: RTL and testbench
====================================

// Module: stopwatch_btn_cmd
// PURPOSE
//  Front end that generates the stopwatch command pulses (start, stop, reset) consumed by the control FSM.
//  Synchronises and debounces two raw pushbuttons: a single start/stop toggle and a reset button.
//  Maps each debounced press to one single-cycle command, using the FSM state fed back on state_in.
//  Sits between board I/O and the stopwatch control FSM.
// PARAMETERS
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a level change; must be >= 2
//  CNT_W            16     debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  reset, asynchronous, active-low
//  btn_ss_raw     in   1  raw start/stop button, asynchronous, active-high, bouncy
//  btn_rst_raw    in   1  raw reset button, asynchronous, active-high, bouncy
//  state_in       in   2  FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED, 11 invalid
//  start          out  1  one-cycle command pulse: enter RUNNING
//  stop           out  1  one-cycle command pulse: enter PAUSED
//  reset          out  1  one-cycle command pulse: return to IDLE
//  ss_db          out  1  debounced start/stop level (debug)
//  rst_db         out  1  debounced reset level (debug)
// BEHAVIOUR
//  - Reset values: all synchroniser flops, counters, debounced levels, edge registers, start/stop/reset,
//    ss_db and rst_db are 0. Assertion is asynchronous. Release is synchronous to the next clk edge.
//  - Synchroniser: each raw input passes through a 2-flop synchroniser (s1 -> s2). Nothing else samples
//    raw inputs.
//  - Debounce, per channel, independent:
//    - If s2 != db, the counter increments each cycle.
//    - If s2 == db, the counter clears to 0 in that cycle.
//    - When the counter would reach DEBOUNCE_CYCLES, db toggles and the counter clears.
//    - The counter never wraps.
//  - Press event: db rises 0->1, detected against a registered copy of db. Releases (1->0) generate nothing.
//  - Latency: raw goes high and stays high, with the first edge sampling 1 counted as edge 1.
//    The command pulse is high for exactly one cycle after edge DEBOUNCE_CYCLES+3.
//  - Glitch rejection: any s2 pulse shorter than DEBOUNCE_CYCLES cycles produces no event and no db change.
//  - Command mapping, registered, one cycle after the press event:
//    - reset press -> reset = 1, whatever state_in is.
//    - start/stop press with state_in 00 or 10 -> start = 1.
//    - start/stop press with state_in 01 -> stop = 1.
//    - start/stop press with state_in 11 -> no command, event dropped.
//  - Simultaneous events: reset and start/stop press in the same cycle -> reset only; the start/stop event
//    is discarded, not deferred.
//  - Exclusivity: at most one of start/stop/reset is high in any cycle, and no output is ever high for two
//    consecutive cycles.
//  - Held button: exactly one event per press, however long the hold. This includes a button held through
//    reset release, which yields one event DEBOUNCE_CYCLES+3 edges after release.
//  - Reset mid-debounce: counters clear. No pulse results from the partial count.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1. Hold rst_n=0 with buttons toggling -> all outputs 0. Release, buttons low 20 cycles -> outputs stay 0.
//  2. state_in=00, btn_ss_raw high from edge 1 for 30 cycles -> start=1 only in the cycle after edge 7,
//     stop=reset=0 throughout; ss_db rises after edge 6.
//  3. btn_ss_raw bounces 1,0,1,1,0,1 then stays high -> exactly one start pulse, no earlier pulse.
//     A separate 3-cycle glitch -> no pulse, ss_db stays 0.
//  4. Three presses with release between each: state_in=01 -> single stop pulse; state_in=10 -> start pulse;
//     state_in=11 -> no pulse.
//  5. Both raw buttons rise in the same cycle, state_in=01 -> reset pulse only, no stop in any later cycle
//     while held.
//  6. btn_rst_raw high for 5 cycles, rst_n pulsed low at edge 5 -> no reset pulse.
//     Button kept high -> one reset pulse 7 edges after rst_n release.

Source files
------------

// File: rtl/stopwatch_btn_cmd.sv
// Stopwatch button front end: sync, debounce, press detect, command map.
// Ports: clk, rst_n, btn_ss_raw, btn_rst_raw, state_in -> start/stop/reset, ss_db, rst_db.

module stopwatch_btn_db #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Count only while the synced level disagrees
  // with db; any agreeing cycle restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      db  <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt <= '0;
        db  <= ~db;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module stopwatch_btn_cmd #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_ss_raw,
  input  logic       btn_rst_raw,
  input  logic [1:0] state_in,
  output logic       start,
  output logic       stop,
  output logic       reset,
  output logic       ss_db,
  output logic       rst_db
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } sw_state_e;

  sw_state_e st;
  logic      ss_q;
  logic      rst_q;
  logic      ss_press;
  logic      rst_press;
  logic      ss_go;

  assign st = sw_state_e'(state_in);

  stopwatch_btn_db #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ss_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_ss_raw),
    .db   (ss_db)
  );

  stopwatch_btn_db #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_rst_db (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (btn_rst_raw),
    .db   (rst_db)
  );

  assign ss_press  = ss_db & ~ss_q;
  assign rst_press = rst_db & ~rst_q;
  // Reset wins; a coincident start/stop press is dropped.
  assign ss_go     = ss_press & ~rst_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_q  <= 1'b0;
      rst_q <= 1'b0;
      start <= 1'b0;
      stop  <= 1'b0;
      reset <= 1'b0;
    end else begin
      ss_q  <= ss_db;
      rst_q <= rst_db;
      start <= 1'b0;
      stop  <= 1'b0;
      reset <= 1'b0;
      unique case (1'b1)
        rst_press: reset <= 1'b1;
        ss_go: begin
          unique case (st)
            ST_IDLE,
            ST_PAUSE: start <= 1'b1;
            ST_RUN:   stop  <= 1'b1;
            default:  ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_btn_cmd.sv
// Bench for stopwatch_btn_cmd: directed + random stimulus,
// window-based reference model, scoreboard monitor.

module tb_stopwatch_btn_cmd;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_ss_raw;
  logic       btn_rst_raw;
  logic [1:0] state_in;
  logic       start;
  logic       stop;
  logic       reset;
  logic       ss_db;
  logic       rst_db;

  stopwatch_btn_cmd #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_ss_raw (btn_ss_raw),
    .btn_rst_raw(btn_rst_raw),
    .state_in   (state_in),
    .start      (start),
    .stop       (stop),
    .reset      (reset),
    .ss_db      (ss_db),
    .rst_db     (rst_db)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] cmd;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cnt_start = 0;
  int   cnt_stop = 0;
  int   cnt_rst = 0;
  int   last_start = -1;
  int   last_rst = -1;
  logic m_ss_db = 1'b0;
  logic m_rs_db = 1'b0;

  task automatic chk(input bit ok, input string nm,
                     input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // A debounced level flips once the last D synced samples
  // (raw as sampled two edges earlier) all differ from it.
  function automatic bit flips(input logic h[$], input logic db);
    for (int j = 0; j < D; j++)
      if (h[h.size() - 3 - j] == db) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model
  initial begin
    logic h_ss[$];
    logic h_rs[$];
    bit   p_ss;
    bit   p_rs;
    p_ss = 0;
    p_rs = 0;
    for (int i = 0; i < D + 2; i++) begin
      h_ss.push_back(1'b0);
      h_rs.push_back(1'b0);
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        h_ss.delete();
        h_rs.delete();
        for (int i = 0; i < D + 2; i++) begin
          h_ss.push_back(1'b0);
          h_rs.push_back(1'b0);
        end
        m_ss_db = 1'b0;
        m_rs_db = 1'b0;
        p_ss = 0;
        p_rs = 0;
      end else begin
        if (p_rs)
          sb.push_back('{cyc, 3'b100});
        else if (p_ss && state_in == 2'b01)
          sb.push_back('{cyc, 3'b010});
        else if (p_ss && state_in != 2'b11)
          sb.push_back('{cyc, 3'b001});
        h_ss.push_back(btn_ss_raw);
        h_rs.push_back(btn_rst_raw);
        if (h_ss.size() > 32) h_ss.pop_front();
        if (h_rs.size() > 32) h_rs.pop_front();
        p_ss = 0;
        p_rs = 0;
        if (flips(h_ss, m_ss_db)) begin
          m_ss_db = ~m_ss_db;
          p_ss = m_ss_db;
        end
        if (flips(h_rs, m_rs_db)) begin
          m_rs_db = ~m_rs_db;
          p_rs = m_rs_db;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [2:0] o;
    logic [2:0] prev;
    exp_t       e;
    prev = 3'b000;
    forever begin
      @(negedge clk);
      o = {reset, stop, start};
      if (!rst_n) begin
        chk(o == 3'b000, "out_in_reset", int'(o), 0);
        chk({ss_db, rst_db} == 2'b00, "db_in_reset",
            int'({ss_db, rst_db}), 0);
        sb.delete();
        prev = 3'b000;
      end else begin
        chk(ss_db == m_ss_db, "ss_db", int'(ss_db), int'(m_ss_db));
        chk(rst_db == m_rs_db, "rst_db", int'(rst_db), int'(m_rs_db));
        chk($countones(o) <= 1, "exclusive", int'(o), 0);
        chk((o & prev) == 3'b000, "consecutive", int'(o), 0);
        if (o != 3'b000) begin
          if (start) begin cnt_start++; last_start = cyc; end
          if (stop) cnt_stop++;
          if (reset) begin cnt_rst++; last_rst = cyc; end
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_pulse", int'(o), 0);
          end else begin
            e = sb.pop_front();
            chk(e.cyc == cyc && e.cmd == o, "pulse",
                int'(o), int'(e.cmd));
          end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          chk(1'b0, "missed_pulse", 0, int'(e.cmd));
        end
        prev = o;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic ss, input logic rs,
                       input logic [1:0] st, input int n);
    btn_ss_raw  = ss;
    btn_rst_raw = rs;
    state_in    = st;
    step(n);
  endtask

  initial begin
    int c0;
    int k0;
    int k1;
    int k2;
    logic [5:0] bounce;
    rst_n       = 1'b0;
    btn_ss_raw  = 1'b0;
    btn_rst_raw = 1'b0;
    state_in    = 2'b00;

    // 1: reset held with toggling buttons, then idle
    for (int i = 0; i < 10; i++)
      drive(i[0], ~i[0], 2'b00, 1);
    btn_ss_raw  = 1'b0;
    btn_rst_raw = 1'b0;
    rst_n = 1'b1;
    drive(0, 0, 2'b00, 20);

    // 2: clean press from IDLE
    c0 = cyc;
    k0 = cnt_start;
    drive(1, 0, 2'b00, 30);
    chk(last_start == c0 + 7, "start_latency", last_start - c0, 7);
    chk(cnt_start - k0 == 1, "single_start", cnt_start - k0, 1);
    drive(0, 0, 2'b00, 10);

    // 3: bounce then hold, then a short glitch
    k0 = cnt_start;
    bounce = 6'b101101;
    for (int i = 5; i >= 0; i--)
      drive(bounce[i], 0, 2'b00, 1);
    drive(1, 0, 2'b00, 20);
    chk(cnt_start - k0 == 1, "bounce_one", cnt_start - k0, 1);
    drive(0, 0, 2'b00, 10);
    k0 = cnt_start;
    drive(1, 0, 2'b00, 3);
    drive(0, 0, 2'b00, 10);
    chk(cnt_start - k0 == 0, "glitch", cnt_start - k0, 0);

    // 4: press in RUNNING, PAUSED, invalid
    k0 = cnt_start;
    k1 = cnt_stop;
    drive(1, 0, 2'b01, 15);
    drive(0, 0, 2'b01, 10);
    chk(cnt_stop - k1 == 1, "run_stop", cnt_stop - k1, 1);
    drive(1, 0, 2'b10, 15);
    drive(0, 0, 2'b10, 10);
    chk(cnt_start - k0 == 1, "pause_start", cnt_start - k0, 1);
    k0 = cnt_start;
    k1 = cnt_stop;
    drive(1, 0, 2'b11, 15);
    drive(0, 0, 2'b11, 10);
    chk(cnt_start + cnt_stop - k0 - k1 == 0, "bad_state",
        cnt_start + cnt_stop - k0 - k1, 0);

    // 5: simultaneous press, reset wins
    k0 = cnt_stop;
    k2 = cnt_rst;
    drive(1, 1, 2'b01, 25);
    drive(0, 0, 2'b01, 10);
    chk(cnt_rst - k2 == 1, "simul_rst", cnt_rst - k2, 1);
    chk(cnt_stop - k0 == 0, "simul_no_stop", cnt_stop - k0, 0);

    // 6: reset mid-debounce, button held through release
    k2 = cnt_rst;
    drive(0, 1, 2'b00, 4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    c0 = cyc;
    step(20);
    chk(cnt_rst - k2 == 1, "hold_thru_rst", cnt_rst - k2, 1);
    chk(last_rst == c0 + 7, "rst_latency", last_rst - c0, 7);
    drive(0, 0, 2'b00, 10);

    // Random phase
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step($urandom_range(1, 2));
        rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            $urandom_range(1, 10));
    end
    drive(0, 0, 2'b00, 20);
    chk(sb.size() == 0, "sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
